// File: rtl/mmu_pkg.sv
// Shared MMU types: TLB<->PTW handshake structs and the PTW arbiter's state/owner encodings.
package mmu_pkg;

    localparam int VPN_W = 27;  // SV39 virtual page number
    localparam int PPN_W = 44;  // SV39 physical page number

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        BUSY  = 2'd2
    } ptw_arb_state_t;

    typedef enum logic {
        OWNER_ITLB = 1'b0,
        OWNER_DTLB = 1'b1
    } ptw_arb_owner_t;

    typedef struct packed {
        logic             valid;
        logic [VPN_W-1:0] vpn;
    } ptw_req_t;

    typedef struct packed {
        logic             valid;
        logic [PPN_W-1:0] ppn;
        logic [1:0]       level;
    } ptw_resp_t;

    typedef struct packed {
        ptw_req_t req;
    } tlb_ptw_comm_t;

    typedef struct packed {
        logic       ptw_ready;
        ptw_resp_t  resp;
        logic [1:0] ptw_status;
        logic       invalidate_tlb;
    } ptw_tlb_comm_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to whoever was not served last.
module rr_arbiter_2
    import mmu_pkg::*;
(
    input  logic [1:0]     req,        // bit 0 = ITLB, bit 1 = DTLB
    input  ptw_arb_owner_t last_owner,
    output ptw_arb_owner_t grant
);

    // Combinational pick; with no request the grant is a don't-care and defaults to ITLB.
    always_comb begin
        grant = OWNER_ITLB;
        if (req == 2'b10) begin
            grant = OWNER_DTLB;
        end else if (req == 2'b11) begin
            if (last_owner == OWNER_ITLB) begin
                grant = OWNER_DTLB;
            end else begin
                grant = OWNER_ITLB;
            end
        end
    end

endmodule

// File: rtl/ptw_arbiter.sv
// Shares one page-table walker between ITLB and DTLB: one walk at a time, grant held
// from offer until the walk response, response routed only to the owning TLB.
module ptw_arbiter
    import mmu_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_i,
    input  tlb_ptw_comm_t itlb_ptw_comm_i,
    input  tlb_ptw_comm_t dtlb_ptw_comm_i,
    output ptw_tlb_comm_t ptw_itlb_comm_o,
    output ptw_tlb_comm_t ptw_dtlb_comm_o,
    output tlb_ptw_comm_t tlb_ptw_comm_o,
    input  ptw_tlb_comm_t ptw_tlb_comm_i,
    output logic          pmu_ptw_conflict_o
);

    ptw_arb_state_t state_reg, state_next;
    ptw_arb_owner_t owner_reg, owner_next;
    ptw_arb_owner_t last_owner_reg, last_owner_next;
    ptw_arb_owner_t grant;
    ptw_arb_owner_t sel_owner;
    logic [1:0]     req_valid;
    logic           drive_req;
    logic           owner_valid;

    assign req_valid = {dtlb_ptw_comm_i.req.valid, itlb_ptw_comm_i.req.valid};

    rr_arbiter_2 u_rr (
        .req        (req_valid),
        .last_owner (last_owner_reg),
        .grant      (grant)
    );

    // In IDLE the live grant steers the mux; once offered or busy the stored owner does.
    assign sel_owner   = (state_reg == IDLE) ? grant : owner_reg;
    assign owner_valid = (owner_reg == OWNER_ITLB) ? itlb_ptw_comm_i.req.valid
                                                   : dtlb_ptw_comm_i.req.valid;
    assign drive_req   = ((state_reg == IDLE) && (req_valid != 2'b00)) || (state_reg == OFFER);

    assign pmu_ptw_conflict_o = (state_reg == IDLE) && (req_valid == 2'b11);

    // State, owner and fairness history; reset drops any walk in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            owner_reg      <= OWNER_ITLB;
            last_owner_reg <= OWNER_DTLB;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
        end
    end

    // Next-state: accept straight to BUSY, park in OFFER until ready, release on response.
    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    owner_next = grant;
                    state_next = ptw_tlb_comm_i.ptw_ready ? BUSY : OFFER;
                end
            end
            OFFER: begin
                if (!owner_valid) begin
                    state_next = IDLE;
                end else if (ptw_tlb_comm_i.ptw_ready) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (ptw_tlb_comm_i.resp.valid) begin
                    state_next      = IDLE;
                    last_owner_next = owner_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output routing: status/invalidate broadcast always, ready and response only to the selected TLB.
    always_comb begin
        tlb_ptw_comm_o  = '0;
        ptw_itlb_comm_o = '0;
        ptw_dtlb_comm_o = '0;

        ptw_itlb_comm_o.ptw_status     = ptw_tlb_comm_i.ptw_status;
        ptw_itlb_comm_o.invalidate_tlb = ptw_tlb_comm_i.invalidate_tlb;
        ptw_dtlb_comm_o.ptw_status     = ptw_tlb_comm_i.ptw_status;
        ptw_dtlb_comm_o.invalidate_tlb = ptw_tlb_comm_i.invalidate_tlb;

        if (drive_req) begin
            if (sel_owner == OWNER_ITLB) begin
                tlb_ptw_comm_o            = itlb_ptw_comm_i;
                ptw_itlb_comm_o.ptw_ready = ptw_tlb_comm_i.ptw_ready;
            end else begin
                tlb_ptw_comm_o            = dtlb_ptw_comm_i;
                ptw_dtlb_comm_o.ptw_ready = ptw_tlb_comm_i.ptw_ready;
            end
        end

        if (state_reg == BUSY) begin
            if (owner_reg == OWNER_ITLB) begin
                ptw_itlb_comm_o.resp = ptw_tlb_comm_i.resp;
            end else begin
                ptw_dtlb_comm_o.resp = ptw_tlb_comm_i.resp;
            end
        end
    end

endmodule
